// File: rtl/apu_pkg.sv
// Shared constants and types for the APU length/channel register block.
// Holds register offsets, read-back OR masks and the length-counter state.
package apu_pkg;

  localparam logic [1:0] NRX1_OFS = 2'd0;
  localparam logic [1:0] NRX2_OFS = 2'd1;
  localparam logic [1:0] NRX3_OFS = 2'd2;
  localparam logic [1:0] NRX4_OFS = 2'd3;

  // Bits that always read back as 1, OR-ed onto the stored register value
  localparam logic [7:0] READ_MASK_NRX2    = 8'h00;
  localparam logic [7:0] READ_MASK_NRX3    = 8'h00;
  localparam logic [7:0] READ_MASK_NRX3_FH = 8'hFF;
  localparam logic [7:0] READ_MASK_NRX4    = 8'hBF;

  function automatic logic [7:0] read_mask_nrx1(input int len_w);
    return 8'((1 << len_w) - 1);
  endfunction

  function automatic logic dac_decode(input logic [7:0] r, input logic has_env);
    return has_env ? (r[7:3] != 5'd0) : r[7];
  endfunction

  // len_cnt is kept 8 bits wide; upper bits stay zero for 6-bit channels
  typedef struct packed {
    logic [7:0] len_cnt;
    logic       len_done;
  } len_state_t;

endpackage

// File: rtl/apu_len_counter.sv
// Length counter: load, 256 Hz tick, trigger reload and expiry pulse.
// APU_LEN_EXTRA_CLK_EN adds the extra clock on a first-half-period len_en 0->1 write.
module apu_len_counter
  import apu_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             napu_reset,
  input  logic             len_tick,
  input  logic             len_en_q,
  input  logic             wr_len,
  input  logic [LEN_W-1:0] load_val,
  input  logic             wr_nr4,
  input  logic             new_len_en,
  input  logic             trig,
  output logic             expire
);

  localparam logic [7:0] CNT_MASK = 8'((1 << LEN_W) - 1);

  len_state_t st_q, st_d;
  logic       extra, tick_ok;

  function automatic len_state_t clk_once(input len_state_t s);
    len_state_t r;
    r = s;
    if (s.len_cnt == CNT_MASK) begin
      r.len_cnt  = 8'd0;
      r.len_done = 1'b1;
    end else begin
      r.len_cnt = s.len_cnt + 8'd1;
    end
    return r;
  endfunction

`ifdef APU_LEN_EXTRA_CLK_EN
  logic half_q, half_d;

  always_ff @(posedge clk or negedge napu_reset)
    if (!napu_reset) half_q <= 1'b0;
    else             half_q <= half_d;

  always_comb begin
    half_d = len_tick ? !half_q : half_q;
    extra  = wr_nr4 && new_len_en && !len_en_q && half_q && !st_q.len_done;
  end
`else
  assign extra = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    expire  = 1'b0;
    // A same-cycle NRx4 write decides len_en; a trigger swallows the tick
    tick_ok = len_tick && (wr_nr4 ? new_len_en : len_en_q) && !st_q.len_done && !trig;
    if (wr_len) begin
      st_d.len_cnt  = 8'(load_val);
      st_d.len_done = 1'b0;
    end else begin
      if (extra || tick_ok) st_d = clk_once(st_q);
      // Trigger on an expired counter reloads; an extra clock then counts once more
      if (trig && st_d.len_done) begin
        st_d.len_cnt  = extra ? 8'd1 : 8'd0;
        st_d.len_done = 1'b0;
      end
      expire = st_d.len_done && !st_q.len_done;
    end
  end

  always_ff @(posedge clk or negedge napu_reset)
    if (!napu_reset) st_q <= '0;
    else             st_q <= st_d;

endmodule

// File: rtl/apu_len_chan_regs.sv
// NRx1..NRx4 register bank, read mux, trigger and channel-active flag for one APU channel.
// APU_LEN_EXTRA_CLK_EN selects the length-enable quirk inside apu_len_counter.
module apu_len_chan_regs
  import apu_pkg::*;
#(
  parameter int LEN_W       = 6,
  parameter int HAS_FREQ_HI = 0,
  parameter int HAS_ENV     = 1
) (
  input  logic                                  clk,
  input  logic                                  napu_reset,
  input  logic                                  wr_en,
  input  logic                                  rd_en,
  input  logic [1:0]                            addr,
  input  logic [7:0]                            wdata,
  output logic [7:0]                            rdata,
  output logic                                  rdata_oe,
  input  logic                                  len_tick,
  output logic [((LEN_W == 8) ? 1 : (8 - LEN_W))-1:0] reg0_hi,
  output logic [7:0]                            reg1_q,
  output logic [7:0]                            reg2_q,
  output logic [2:0]                            freq_hi,
  output logic                                  len_en,
  output logic                                  ch_restart,
  output logic                                  ch_active,
  output logic                                  dac_on
);

  localparam int HI_W = (LEN_W == 8) ? 1 : (8 - LEN_W);

  logic [HI_W-1:0] reg0_hi_q, reg0_hi_d;
  logic [7:0]      reg1_d, reg2_d;
  logic [2:0]      freq_hi_q, freq_hi_d;
  logic            len_en_q, len_en_d;
  logic            ch_restart_q, ch_active_q, ch_active_d;
  logic            wr0, wr1, wr2, wr3, trig, len_expire;

  assign wr0  = wr_en && (addr == NRX1_OFS);
  assign wr1  = wr_en && (addr == NRX2_OFS);
  assign wr2  = wr_en && (addr == NRX3_OFS);
  assign wr3  = wr_en && (addr == NRX4_OFS);
  assign trig = wr3 && wdata[7];

  assign dac_on = dac_decode(reg1_q, HAS_ENV != 0);

  apu_len_counter #(.LEN_W(LEN_W)) u_len (
    .clk        (clk),
    .napu_reset (napu_reset),
    .len_tick   (len_tick),
    .len_en_q   (len_en_q),
    .wr_len     (wr0),
    .load_val   (wdata[LEN_W-1:0]),
    .wr_nr4     (wr3),
    .new_len_en (wdata[6]),
    .trig       (trig),
    .expire     (len_expire)
  );

  always_comb begin
    reg0_hi_d   = reg0_hi_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    freq_hi_d   = freq_hi_q;
    len_en_d    = len_en_q;
    ch_active_d = ch_active_q;
    if (wr0) reg0_hi_d = HI_W'(wdata >> LEN_W);
    if (wr1) reg1_d = wdata;
    if (wr2) reg2_d = wdata;
    if (wr3) begin
      len_en_d = wdata[6];
      if (HAS_FREQ_HI != 0) freq_hi_d = wdata[2:0];
    end
    // Writing NRx2 with the DAC off kills the channel in the same edge
    if (len_expire || (wr1 && !dac_decode(wdata, HAS_ENV != 0))) ch_active_d = 1'b0;
    if (trig) ch_active_d = dac_on;
  end

  always_ff @(posedge clk or negedge napu_reset)
    if (!napu_reset) begin
      reg0_hi_q    <= '0;
      reg1_q       <= 8'h00;
      reg2_q       <= 8'h00;
      freq_hi_q    <= 3'd0;
      len_en_q     <= 1'b0;
      ch_restart_q <= 1'b0;
      ch_active_q  <= 1'b0;
    end else begin
      reg0_hi_q    <= reg0_hi_d;
      reg1_q       <= reg1_d;
      reg2_q       <= reg2_d;
      freq_hi_q    <= freq_hi_d;
      len_en_q     <= len_en_d;
      ch_restart_q <= trig;
      ch_active_q  <= ch_active_d;
    end

  always_comb begin
    rdata = 8'h00;
    if (rd_en)
      case (addr)
        NRX1_OFS: rdata = (8'(reg0_hi_q) << LEN_W) | read_mask_nrx1(LEN_W);
        NRX2_OFS: rdata = reg1_q | READ_MASK_NRX2;
        NRX3_OFS: rdata = reg2_q | ((HAS_FREQ_HI != 0) ? READ_MASK_NRX3_FH : READ_MASK_NRX3);
        default:  rdata = {1'b0, len_en_q, 6'b000000} | READ_MASK_NRX4;
      endcase
  end

  assign rdata_oe   = rd_en;
  assign reg0_hi    = reg0_hi_q;
  assign freq_hi    = freq_hi_q;
  assign len_en     = len_en_q;
  assign ch_restart = ch_restart_q;
  assign ch_active  = ch_active_q;

endmodule

// File: tb/tb_apu_len_chan_regs.sv
// Bench for apu_len_chan_regs: two configurations (6-bit with freq-hi/envelope, 8-bit plain)
// driven in parallel and compared every cycle against a behavioural channel model.
module tb_apu_len_chan_regs;

  logic       clk = 1'b0, napu_reset = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, len_tick = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] rdata_a, r1_a, r2_a, rdata_b, r1_b, r2_b;
  logic [2:0] fh_a, fh_b;
  logic [1:0] hi_a;
  logic [0:0] hi_b;
  logic       oe_a, le_a, rs_a, act_a, dac_a, oe_b, le_b, rs_b, act_b, dac_b;

  int nchk = 0, npass = 0;

  always #5 clk = ~clk;

  apu_len_chan_regs #(.LEN_W(6), .HAS_FREQ_HI(1), .HAS_ENV(1)) dut6 (
    .clk(clk), .napu_reset(napu_reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata_a), .rdata_oe(oe_a), .len_tick(len_tick), .reg0_hi(hi_a),
    .reg1_q(r1_a), .reg2_q(r2_a), .freq_hi(fh_a), .len_en(le_a), .ch_restart(rs_a),
    .ch_active(act_a), .dac_on(dac_a));

  apu_len_chan_regs #(.LEN_W(8), .HAS_FREQ_HI(0), .HAS_ENV(0)) dut8 (
    .clk(clk), .napu_reset(napu_reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .rdata_oe(oe_b), .len_tick(len_tick), .reg0_hi(hi_b),
    .reg1_q(r1_b), .reg2_q(r2_b), .freq_hi(fh_b), .len_en(le_b), .ch_restart(rs_b),
    .ch_active(act_b), .dac_on(dac_b));

  // Behavioural model of one channel
  typedef struct {
    int       cnt;
    bit       done;
    int       hi;
    bit [7:0] r1, r2;
    bit [2:0] fh;
    bit       le, rs, act, half;
  } mstate_t;

  mstate_t ms [2];

  function automatic bit dac(input bit [7:0] r, input bit env);
    return env ? (r[7:3] != 0) : r[7];
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input int lw, input bit fh, input bit env,
                                     input bit we, input bit [1:0] a, input bit [7:0] d,
                                     input bit tick);
    mstate_t n;
    int lim;
    bit trig, extra;
    n = s;
    lim = 1 << lw;
    trig = we && a == 3 && d[7];
    extra = 0;
    n.rs = trig;
    if (we)
      case (a)
        0: begin n.cnt = d % lim; n.hi = d / lim; n.done = 0; end
        1: begin n.r1 = d; if (!dac(d, env)) n.act = 0; end
        2: n.r2 = d;
        default: begin n.le = d[6]; if (fh) n.fh = d[2:0]; end
      endcase
`ifdef APU_LEN_EXTRA_CLK_EN
    if (tick) n.half = !s.half;
    extra = we && a == 3 && d[6] && !s.le && s.half && !s.done;
`endif
    if (extra || (tick && n.le && !s.done && !(we && a == 0) && !trig)) begin
      n.cnt = s.cnt + 1;
      if (n.cnt == lim) begin n.cnt = 0; n.done = 1; n.act = 0; end
    end
    if (trig) begin
      n.act = dac(s.r1, env);
      if (n.done) begin n.cnt = extra ? 1 : 0; n.done = 0; end
    end
    return n;
  endfunction

  function automatic logic [33:0] exp_out(input mstate_t s, input int lw, input bit fh,
                                          input bit env, input bit rd, input bit [1:0] a);
    bit [7:0] v;
    v = 0;
    if (rd)
      case (a)
        0: v = 8'(s.hi * (1 << lw) + (1 << lw) - 1);
        1: v = s.r1;
        2: v = fh ? 8'hFF : s.r2;
        default: v = 8'hBF | (8'(s.le) << 6);
      endcase
    return {v, rd, 2'(s.hi), s.r1, s.r2, s.fh, s.le, s.rs, s.act, dac(s.r1, env)};
  endfunction

  always @(posedge clk or negedge napu_reset)
    if (!napu_reset) begin
      ms[0] <= '{default: 0};
      ms[1] <= '{default: 0};
    end else begin
      ms[0] <= m_next(ms[0], 6, 1, 1, wr_en, addr, wdata, len_tick);
      ms[1] <= m_next(ms[1], 8, 0, 0, wr_en, addr, wdata, len_tick);
    end

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("dut6 outputs", {rdata_a, oe_a, hi_a, r1_a, r2_a, fh_a, le_a, rs_a, act_a, dac_a},
        exp_out(ms[0], 6, 1, 1, rd_en, addr));
    chk("dut8 outputs", {rdata_b, oe_b, 1'b0, hi_b, r1_b, r2_b, fh_b, le_b, rs_b, act_b, dac_b},
        exp_out(ms[1], 8, 0, 0, rd_en, addr));
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic t = 1'b0);
    wr_en = 1'b1; addr = a; wdata = d; len_tick = t;
    @(posedge clk); #1;
    wr_en = 1'b0; len_tick = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      len_tick = 1'b1;
      @(posedge clk); #1;
    end
    len_tick = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [7:0] e6,
                    input logic [7:0] e8);
    rd_en = 1'b1; addr = a; #2;
    chk({name, " dut6"}, 34'(rdata_a), 34'(e6));
    chk({name, " dut8"}, 34'(rdata_b), 34'(e8));
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("reset outputs dut6", {rdata_a, oe_a, hi_a, r1_a, r2_a, fh_a, le_a, rs_a, act_a, dac_a}, 34'd0);
    napu_reset = 1'b1;
    @(posedge clk); #1;

    // 6-bit length: 0x3C expires on the 4th tick
    wr(0, 8'h3C); wr(1, 8'hF0); wr(3, 8'hC0);
    chk("trigger restart pulse", 34'(rs_a), 34'd1);
    chk("trigger active", 34'(act_a), 34'd1);
    @(posedge clk); #1;
    chk("restart one clk", 34'(rs_a), 34'd0);
    tick(3); chk("active after 3 ticks", 34'(act_a), 34'd1);
    tick(1); chk("expired on 4th tick", 34'(act_a), 34'd0);

    // Asynchronous reset mid-count
    wr(0, 8'h08); wr(3, 8'hC0); tick(2);
    chk("active before reset", 34'(act_a), 34'd1);
    #2 napu_reset = 1'b0; #1;
    chk("async reset dut6", {rdata_a, oe_a, hi_a, r1_a, r2_a, fh_a, le_a, rs_a, act_a, dac_a}, 34'd0);
    chk("async reset dut8", {rdata_b, oe_b, 1'b0, hi_b, r1_b, r2_b, fh_b, le_b, rs_b, act_b, dac_b}, 34'd0);
    @(posedge clk); #1;
    napu_reset = 1'b1;
    @(posedge clk); #1;

    // 8-bit length: 0xFF expires in 1 tick, retrigger reload needs 256
    wr(1, 8'h80); wr(0, 8'hFF); wr(3, 8'hC0);
    chk("len8 active", 34'(act_b), 34'd1);
    tick(1); chk("len8 expire after 1 tick", 34'(act_b), 34'd0);
    wr(3, 8'hC0); chk("len8 retrigger active", 34'(act_b), 34'd1);
    tick(255); chk("len8 active after 255", 34'(act_b), 34'd1);
    tick(1); chk("len8 expired after 256", 34'(act_b), 34'd0);

    // DAC off
    wr(1, 8'h07); wr(3, 8'hC0);
    chk("dac off trigger dut6", 34'(act_a), 34'd0);
    chk("dac off trigger dut8", 34'(act_b), 34'd0);
    wr(1, 8'hF0); wr(3, 8'h80);
    chk("dac on trigger", 34'(act_a), 34'd1);
    wr(1, 8'h00); chk("reg1 zero kills channel", 34'(act_a), 34'd0);

    // Collisions: load beats tick, trigger beats tick
    wr(1, 8'hF0); wr(0, 8'h00); wr(3, 8'hC0);
    tick(3); wr(0, 8'h20, 1'b1);
    tick(31); chk("load wins over tick, 31", 34'(act_a), 34'd1);
    tick(1); chk("load wins over tick, 32", 34'(act_a), 34'd0);
    wr(0, 8'h3E); wr(3, 8'hC0, 1'b1);
    chk("trigger with tick active", 34'(act_a), 34'd1);
    tick(1); chk("tick dropped on trigger", 34'(act_a), 34'd1);
    tick(1); chk("expire after 2 ticks", 34'(act_a), 34'd0);

    // Read-back
    wr(2, 8'h55); wr(0, 8'h80); wr(3, 8'h40);
    rd(0, "read nrx1", 8'hBF, 8'hFF);
    rd(2, "read nrx3", 8'hFF, 8'h55);
    rd(3, "read nrx4", 8'hFF, 8'hFF);

    // Randomised traffic, checked by the per-cycle compare
    for (int i = 0; i < 4000; i++) begin
      wr_en = ($urandom_range(0, 99) < 30);
      addr  = 2'($urandom);
      wdata = 8'($urandom);
      if (addr == 2'd3) wdata[6] = ($urandom_range(0, 3) != 0);
      if (addr == 2'd1 && $urandom_range(0, 3) != 0) wdata[7] = 1'b1;
      rd_en    = 1'($urandom);
      len_tick = ($urandom_range(0, 99) < 30);
      @(posedge clk); #1;
    end
    wr_en = 1'b0; rd_en = 1'b0; len_tick = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/apu_len_chan_regs.md
Name: apu_len_chan_regs

Overview:
- Parametrised, clocked register bank for one APU sound channel: the NRx1–NRx4 registers plus the length counter, trigger logic and channel-active flag.
- Successor to the latch-based channel-4 register page.
- Length width and frequency-high field are parameters, so one block serves channels 1–4.
- Sits between the APU bus decode (address offset, write/read strobes) and the channel's envelope, frequency and waveform logic.

Parameters:
- LEN_W, 6, length counter width; 6 for ch1/2/4, 8 for ch3; legal values 6 or 8.
- HAS_FREQ_HI, 0, 1 = reg3 bits[2:0] hold frequency high bits and reg2 is write-only.
- HAS_ENV, 1, 1 = reg1 is an envelope register (DAC on when reg1[7:3] != 0); 0 = DAC is reg1[7] only.

Ports:
- clk  in  1  APU clock
- napu_reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one clk
- rd_en  in  1  read strobe
- addr  in  2  register offset 0..3 (NRx1..NRx4)
- wdata  in  8  write data
- rdata  out  8  read data
- rdata_oe  out  1  read data valid (= rd_en)
- len_tick  in  1  256 Hz length clock enable, one clk wide
- reg0_hi  out  8-LEN_W  reg0 bits above the length field (duty), 2 bits when LEN_W=6; tie-off width 1, value 0, when LEN_W=8
- reg1_q  out  8  envelope / level register
- reg2_q  out  8  poly counter or frequency low
- freq_hi  out  3  reg3[2:0]; 0 when HAS_FREQ_HI=0
- len_en  out  1  reg3[6]
- ch_restart  out  1  trigger pulse, one clk
- ch_active  out  1  channel-on status
- dac_on  out  1  DAC enable, decoded from reg1

Behaviour:
- Reset, asynchronous on napu_reset low: all registers, len_cnt, len_done, ch_restart and ch_active = 0. rdata reflects register state, combinationally.
- Write, addr 0: len_cnt <= wdata[LEN_W-1:0], reg0_hi <= upper bits, len_done <= 0.
- Write, addr 1: reg1 <= wdata. If the resulting dac_on = 0, ch_active <= 0 in the same edge.
- Write, addr 2: reg2 <= wdata.
- Write, addr 3: len_en <= wdata[6]; freq_hi <= wdata[2:0] if HAS_FREQ_HI.
- Trigger: a write to addr 3 with wdata[7] = 1.
  - ch_restart = 1 for exactly the next clk.
  - ch_active <= dac_on.
  - If len_done: len_cnt <= 0, len_done <= 0.
- Length count: on len_tick with len_en = 1 and len_done = 0:
  - len_cnt <= len_cnt + 1, modulo 2^LEN_W.
  - When len_cnt is all-ones, it wraps to 0, len_done <= 1 and ch_active <= 0.
  - Expiry therefore takes 2^LEN_W − loaded value ticks.
- Simultaneous events:
  - Write to addr 0 during len_tick: the write wins and the tick is dropped.
  - Trigger during len_tick: the trigger wins and the tick is dropped.
  - Write addr 3 clearing len_en during len_tick: the new len_en applies, so no count.
- dac_on is combinational from reg1.
- Latency: written values are visible on outputs one clk after wr_en.
- Reads, combinational, active while rd_en:
  - addr0 = {reg0_hi, all-ones length field}
  - addr1 = reg1
  - addr2 = 0xFF if HAS_FREQ_HI, else reg2
  - addr3 = {1, len_en, 6'b111111}
- len_cnt is not readable.

Optional Feature:
- Macro APU_LEN_EXTRA_CLK_EN.
- Defined: models the length-enable quirk.
  - A half-phase flag, set by len_tick and cleared by the next len_tick, is kept internally.
  - If a write to addr 3 changes len_en 0→1 while the flag indicates the first half of the 256 Hz period, the counter is clocked once immediately, with expiry rules as above.
  - If that extra clock expires the counter and the same write triggers, len_cnt reloads to 0, then is clocked once more, to 1.
- Undefined: len_en changes never clock the counter.

Decomposition:
- Package apu_pkg holds:
  - register offset constants NRX1_OFS..NRX4_OFS
  - READ_MASK constants per register
  - typedef len_state_t {len_cnt, len_done}
- One sub-module, apu_len_counter, parameterised by LEN_W.
  - Owns len_cnt, len_done, the extra-clock flag and all tick/load/reload priority.
  - Emits an expire pulse.
- The top level holds the register bank, read mux, trigger and ch_active.

Test Plan:
- Reset: drive napu_reset low mid-count, with len_cnt=10 and ch_active=1 → all outputs 0 immediately, no clk required.
- LEN_W=6: write addr0=0x3C, addr1=0xF0, addr3=0xC0 → ch_restart pulse 1 clk; ch_active=1; cleared on the 4th len_tick; len_done=1.
- LEN_W=8: write addr0=0xFF, then trigger with len_en=1 → expires after 1 tick. A retrigger reloads to 0 → needs 256 ticks.
- DAC off: trigger with reg1=0x07 → ch_active stays 0. With ch_active=1, write reg1=0x00 → ch_active=0 next clk.
- Collisions: len_tick coincides with an addr0 write of 0x20 → len_cnt=0x20, not 0x21. Trigger coincides with len_tick → the tick is ignored.
- Read-back: HAS_FREQ_HI=1, reg2=0x55, len_en=1, reg0_hi=2'b10 → addr0=0xBF, addr2=0xFF, addr3=0xFF. With APU_LEN_EXTRA_CLK_EN: len_en 0→1 in the first half-period with len_cnt=5 → len_cnt=6 the next clk.
